// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial adder controller: runs cla_4bit over WIDTH-bit operands, LSB nibble first.
// Optional subtract mode (port `sub`) is enabled by defining SEQ_ADD_SUB_EN.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end
endmodule

module cla_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CW-1:0]    cnt;
  logic             carry, a_msb, b_msb;
  logic             accept, last;
  logic [WIDTH-1:0] b_init;
  logic             c_init;

  logic [3:0] s1, s2;
  logic       c1, c2, carry_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Subtraction folds into the captured operand: ~B with carry-in forced to 1
`ifdef SEQ_ADD_SUB_EN
  assign b_init = sub ? ~B : B;
  assign c_init = sub ? 1'b1 : Cin;
`else
  assign b_init = B;
  assign c_init = Cin;
`endif

  cla_4bit u_add_ab (.a(a_sh[3:0]), .b(b_sh[3:0]),       .cin(1'b0), .sum(s1), .cout(c1));
  cla_4bit u_add_c  (.a(s1),        .b({3'b000, carry}), .cin(1'b0), .sum(s2), .cout(c2));

  assign carry_nxt = c1 | c2;
  assign res_nxt   = {s2, res_sh[WIDTH-1:4]};

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        accept  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh  <= A;
        b_sh  <= b_init;
        carry <= c_init;
        cnt   <= '0;
        a_msb <= A[WIDTH-1];
        b_msb <= b_init[WIDTH-1];
      end else if (busy) begin
        a_sh   <= a_sh >> 4;
        b_sh   <= b_sh >> 4;
        res_sh <= res_nxt;
        carry  <= carry_nxt;
        cnt    <= cnt + CW'(1);
      end
      // Final nibble goes straight to the outputs; res_sh is one step behind here
      if (last) begin
        Sum  <= res_nxt;
        Cout <= carry_nxt;
        Ovf  <= (a_msb == b_msb) && (s2[3] != a_msb);
      end
    end
  end
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Scoreboard bench for cla_serial_add_ctrl: stimulus pushes expected results, a monitor checks each done.
module tb_cla_serial_add_ctrl;
  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, Cout, Ovf;
  logic [W-1:0] Sum;

  cla_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
`ifdef SEQ_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the full-width operands
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s, input int dcyc);
    exp_t e;
    logic [W-1:0] be;
    logic         ci;
    longint       t, sa, sb;
    be = s ? ~b : b;
    ci = s ? 1'b1 : c;
    t  = longint'(a) + longint'(be) + longint'(ci);
    sa = longint'($signed(a));
    sb = longint'($signed(be));
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = ((sa + sb + longint'(ci)) > 32767) || ((sa + sb + longint'(ci)) < -32768);
    e.done_cyc = dcyc;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_done_exclusive", longint'(busy && done), 0);
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum", longint'(Sum), longint'(e.sum));
          check("cout", longint'(Cout), longint'(e.cout));
          check("ovf", longint'(Ovf), longint'(e.ovf));
          check("done_latency", longint'(cyc), longint'(e.done_cyc));
          check("busy_cycles", longint'(busy_cnt), longint'(N));
        end
        busy_cnt = 0;
      end
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    @(negedge clk);
    A = a; B = b; Cin = c; sub = s; start = 1'b1;
    exp_q.push_back(model(a, b, c, s, cyc + 1 + int'(N)));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("drain_timeout", 1, 0);
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t e1;
    bit   seen;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_sum", longint'(Sum), 0);
    check("rst_cout", longint'(Cout), 0);
    check("rst_ovf", longint'(Ovf), 0);
    rst_n = 1'b1;

    // Directed cases
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();
    launch(16'h1234, 16'h0FED, 1'b1, 1'b0); drain();

    // Start pulse two cycles into RUN must be ignored
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    A = 16'hAAAA; B = 16'h5555; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain();

    // Reset mid-RUN: outputs clear without a clock edge
    launch(16'h4321, 16'h1234, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_busy", longint'(busy), 0);
    check("arst_done", longint'(done), 0);
    check("arst_sum", longint'(Sum), 0);
    check("arst_cout", longint'(Cout), 0);
    check("arst_ovf", longint'(Ovf), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_idle", longint'(busy || done), 0);
    launch(16'h00FF, 16'h0F01, 1'b0, 1'b0); drain();

    // Start held across DONE: back-to-back with no IDLE cycle
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; Cin = 1'b0; sub = 1'b0; start = 1'b1;
    e1 = model(16'h1111, 16'h2222, 1'b0, 1'b0, cyc + 1 + int'(N));
    exp_q.push_back(e1);
    exp_q.push_back(model(16'h0003, 16'h0004, 1'b0, 1'b0, cyc + 2 + 2 * int'(N)));
    @(posedge clk); #1;
    A = 16'h0003; B = 16'h0004;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) check("b2b_done_timeout", 1, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("b2b_sum_held", longint'(Sum), longint'(e1.sum));
    drain();

`ifdef SEQ_ADD_SUB_EN
    launch(16'h0005, 16'h0007, 1'b0, 1'b1); drain();
    launch(16'h8000, 16'h0001, 1'b1, 1'b1); drain();
`endif

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      logic s;
`ifdef SEQ_ADD_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), s);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
